rks_loader: RTL and testbench

- Sits between the ARM data_io download stream and the SDRAM write port.
- Parses RKS tape-image files: 4-byte header (start and end address, little-endian), payload, then 2-byte checksum.
- Writes the payload to RAM at the header addresses and verifies the checksum.
- Reports start address, completion and error status to the top level, which holds the CPU in reset while the loader is busy.

---
 rtl/spec_pkg.sv | 20 ++
 rtl/rks_csum.sv | 26 ++
 rtl/rks_loader.sv | 175 +++++++++++++++++
 tb/tb_rks_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spec_pkg.sv
// Shared types and constants for the RKS tape-image loader.
package spec_pkg;

    typedef enum logic [3:0] {
        IDLE,
        H0,
        H1,
        H2,
        H3,
        DATA,
        CSH,
        CSL,
        TAIL,
        ERR
    } rks_state_t;

    localparam int RKS_HDR_LEN = 4;
    localparam int RKS_CS_LEN  = 2;

endpackage

// File: rtl/rks_csum.sv
// RKS checksum accumulator: adds {b,b} per payload byte, the last byte only into the low half.
module rks_csum (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic        last,
    input  logic [7:0]  b,
    output logic [15:0] cs
);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            cs <= 16'h0000;
        end else if (clear) begin
            cs <= 16'h0000;
        end else if (en) begin
            if (last) begin
                cs[7:0] <= cs[7:0] + b;
            end else begin
                cs <= cs + {b, b};
            end
        end
    end

endmodule

// File: rtl/rks_loader.sv
// RKS tape-image loader: parses the header, writes the payload to RAM and verifies the checksum.
//   state | meaning
//   IDLE  | waiting for a download start with our index
//   H0-H3 | collecting start_lo, start_hi, end_lo, end_hi
//   DATA  | payload bytes, one RAM write each
//   CSH   | expected checksum high byte
//   CSL   | expected checksum low byte, compare
//   TAIL  | file complete, ignoring trailing bytes until download ends
//   ERR   | failed file, ignoring bytes until download ends
module rks_loader
    import spec_pkg::*;
#(
    parameter bit         CS_CHECK = 1'b1,
    parameter logic [4:0] INDEX    = 5'd0
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [4:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [7:0]  ioctl_data,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_din,
    output logic        mem_we,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] start_addr
);

    rks_state_t  state;
    rks_state_t  state_nxt;
    rks_state_t  cur;

    logic        dl_prev;
    logic [15:0] hdr_start;
    logic [7:0]  end_lo;
    logic [7:0]  exp_hi;
    logic [15:0] addr_q;
    logic [16:0] cnt_q;
    logic [15:0] cs;

    logic        sel;
    logic        accept;
    logic        fall;
    logic        take;
    logic        abort;
    logic [15:0] end_word;
    logic        hdr_bad;
    logic        last_byte;
    logic        cs_ok;
    logic        set_err;
    logic        do_done;

    assign sel       = (ioctl_index == INDEX);
    assign accept    = ioctl_download & ~dl_prev & sel;
    assign fall      = ~ioctl_download & dl_prev;
    assign abort     = ~accept & fall & (state != IDLE);
    assign cur       = accept ? H0 : state;
    assign take      = ioctl_wr & sel & ~abort;
    assign end_word  = {ioctl_data, end_lo};
    assign hdr_bad   = (end_word < hdr_start);
    assign last_byte = (cnt_q == 17'd1);
    assign cs_ok     = ({exp_hi, ioctl_data} == cs);
    assign busy      = (state != IDLE);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = cur;
        set_err   = 1'b0;
        do_done   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
            if (state inside {H0, H1, H2, H3, DATA, CSH, CSL}) begin
                set_err = 1'b1;
            end
            if (state == TAIL) begin
                do_done = 1'b1;
            end
        end else if (take) begin
            unique case (cur)
                H0:   state_nxt = H1;
                H1:   state_nxt = H2;
                H2:   state_nxt = H3;
                H3: begin
                    if (hdr_bad) begin
                        state_nxt = ERR;
                        set_err   = 1'b1;
                    end else begin
                        state_nxt = DATA;
                    end
                end
                DATA: state_nxt = last_byte ? CSH : DATA;
                CSH:  state_nxt = CSL;
                CSL: begin
                    if (CS_CHECK && !cs_ok) begin
                        state_nxt = ERR;
                        set_err   = 1'b1;
                    end else begin
                        state_nxt = TAIL;
                    end
                end
                default: state_nxt = cur;
            endcase
        end
    end

    // dl_prev resets high so a download already in progress at reset release is not taken as a new start.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            dl_prev    <= 1'b1;
            hdr_start  <= 16'h0000;
            end_lo     <= 8'h00;
            exp_hi     <= 8'h00;
            addr_q     <= 16'h0000;
            cnt_q      <= 17'd0;
            mem_addr   <= 16'h0000;
            mem_din    <= 8'h00;
            mem_we     <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            start_addr <= 16'h0000;
        end else begin
            dl_prev <= ioctl_download;
            mem_we  <= 1'b0;
            done    <= do_done;
            if (accept) begin
                error <= 1'b0;
                cnt_q <= 17'd0;
            end
            if (set_err) begin
                error <= 1'b1;
            end
            if (take) begin
                unique case (cur)
                    H0: hdr_start[7:0]  <= ioctl_data;
                    H1: hdr_start[15:8] <= ioctl_data;
                    H2: end_lo          <= ioctl_data;
                    H3: begin
                        start_addr <= hdr_start;
                        addr_q     <= hdr_start;
                        cnt_q      <= {1'b0, end_word} - {1'b0, hdr_start} + 17'd1;
                    end
                    DATA: begin
                        mem_we   <= 1'b1;
                        mem_addr <= addr_q;
                        mem_din  <= ioctl_data;
                        addr_q   <= addr_q + 16'd1;
                        cnt_q    <= cnt_q - 17'd1;
                    end
                    CSH: exp_hi <= ioctl_data;
                    default: ;
                endcase
            end
        end
    end

    rks_csum u_csum (
        .clk_sys (clk_sys),
        .reset   (reset),
        .clear   (accept),
        .en      (take && (cur == DATA)),
        .last    (last_byte),
        .b       (ioctl_data),
        .cs      (cs)
    );

endmodule

// File: tb/tb_rks_loader.sv
// Scoreboard bench for rks_loader: file-level reference model predicts RAM writes and status.
module tb_rks_loader;

    localparam logic [4:0] IDX = 5'd0;

    logic        clk_sys = 1'b0;
    logic        reset = 1'b1;
    logic        ioctl_download = 1'b0;
    logic [4:0]  ioctl_index = 5'd0;
    logic        ioctl_wr = 1'b0;
    logic [7:0]  ioctl_data = 8'h00;
    logic [15:0] mem_addr;
    logic [7:0]  mem_din;
    logic        mem_we;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] start_addr;

    rks_loader #(.CS_CHECK(1'b1), .INDEX(IDX)) dut (
        .clk_sys        (clk_sys),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_index    (ioctl_index),
        .ioctl_wr       (ioctl_wr),
        .ioctl_data     (ioctl_data),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_we         (mem_we),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .start_addr     (start_addr)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        int          due;
    } wr_t;

    wr_t        exp_q[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    bit         last_err = 1'b0;
    logic [7:0] fixed_pay[$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every RAM write must match the oldest expected write, address, data and cycle.
    always @(negedge clk_sys) begin
        if (done === 1'b1) done_cnt++;
        if (mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {mem_addr, mem_din}, 32'h0);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 32'(mem_addr), 32'(w.a));
                chk("wr_data", 32'(mem_din), 32'(w.d));
                chk("wr_cycle", 32'(cyc), 32'(w.due));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit push, input logic [15:0] a);
        wr_t w;
        ioctl_wr   = 1'b1;
        ioctl_data = b;
        if (push) begin
            w.a = a; w.d = b; w.due = cyc + 1;
            exp_q.push_back(w);
        end
        tick(1);
        ioctl_wr = 1'b0;
        tick($urandom_range(1, 2));
    endtask

    // Reference: checksum from the file rules, plain integer arithmetic.
    task automatic run_file(input logic [15:0] s, input logic [15:0] e, input int n_send_req,
                            input bit cs_bad, input int tail_n, input logic [4:0] idx, input bit same);
        logic [7:0]  st[$];
        logic [7:0]  pay[$];
        logic [15:0] cs;
        int len, full, n_send, first, sum, d0;
        bit hdr_bad, match, trunc, exp_err, exp_done;
        hdr_bad = (e < s);
        match   = (idx == IDX);
        st = {s[7:0], s[15:8], e[7:0], e[15:8]};
        len = 0;
        if (!hdr_bad) begin
            len = int'(e) - int'(s) + 1;
            for (int i = 0; i < len; i++)
                pay.push_back((fixed_pay.size() == len) ? fixed_pay[i] : 8'($urandom));
            sum = 0;
            for (int i = 0; i < len - 1; i++) sum = (sum + int'(pay[i]) * 257) % 65536;
            sum = (sum / 256) * 256 + ((sum % 256) + int'(pay[len-1])) % 256;
            cs = 16'(sum);
            if (cs_bad) cs = cs ^ 16'($urandom_range(1, 65535));
            foreach (pay[i]) st.push_back(pay[i]);
            st.push_back(cs[15:8]);
            st.push_back(cs[7:0]);
        end
        full = st.size();
        for (int i = 0; i < tail_n; i++) st.push_back(8'($urandom));
        n_send = (n_send_req < 0) ? st.size() : n_send_req;
        trunc  = hdr_bad ? (n_send < 4) : (n_send < full);
        exp_err  = match ? (hdr_bad | trunc | cs_bad) : last_err;
        exp_done = match & ~hdr_bad & ~trunc & ~cs_bad;
        fixed_pay.delete();

        ioctl_index = idx;
        tick(1);
        d0 = done_cnt;
        first = 0;
        if (same && n_send > 0) begin
            ioctl_download = 1'b1;
            send_byte(st[0], 1'b0, 16'h0);
            first = 1;
        end else begin
            ioctl_download = 1'b1;
            tick(2);
        end
        for (int i = first; i < n_send; i++)
            send_byte(st[i], match && !hdr_bad && i >= 4 && i < 4 + len, s + 16'(i - 4));
        tick(2);
        chk("busy_during", 32'(busy), 32'(match));
        if (match && n_send >= 4 && hdr_bad) chk("err_hdr", 32'(error), 32'h1);
        if (match && n_send >= 4 && !hdr_bad) chk("start_addr", 32'(start_addr), 32'(s));
        if (match && !hdr_bad && n_send >= full && cs_bad) chk("err_cs_early", 32'(error), 32'h1);
        ioctl_download = 1'b0;
        tick(3);
        chk("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
        chk("busy_after", 32'(busy), 32'h0);
        chk("error_after", 32'(error), 32'(exp_err));
        chk("missing_writes", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        last_err = exp_err;
    endtask

    task automatic reset_mid_data();
        int d0;
        wr_t w;
        ioctl_index = IDX;
        tick(1);
        d0 = done_cnt;
        ioctl_download = 1'b1;
        tick(2);
        send_byte(8'h00, 1'b0, 16'h0);
        send_byte(8'h50, 1'b0, 16'h0);
        send_byte(8'h05, 1'b0, 16'h0);
        send_byte(8'h50, 1'b0, 16'h0);
        send_byte(8'hA1, 1'b1, 16'h5000);
        ioctl_wr = 1'b1;
        ioctl_data = 8'hB2;
        tick(1);
        ioctl_wr = 1'b0;
        #1;
        chk("we_before_rst", 32'(mem_we), 32'h1);
        reset = 1'b1;
        #1;
        chk("we_at_rst", 32'(mem_we), 32'h0);
        chk("busy_at_rst", 32'(busy), 32'h0);
        chk("error_at_rst", 32'(error), 32'h0);
        tick(1);
        reset = 1'b0;
        tick(1);
        for (int i = 0; i < 3; i++) send_byte(8'(8'hC0 + i), 1'b0, 16'h0);
        chk("busy_post_rst", 32'(busy), 32'h0);
        ioctl_download = 1'b0;
        tick(3);
        chk("done_post_rst", 32'(done_cnt - d0), 32'h0);
        chk("error_post_rst", 32'(error), 32'h0);
        chk("missing_rst", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        last_err = 1'b0;
    endtask

    initial begin
        logic [15:0] s, e;
        int len, r, nsend;
        tick(2);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_start", 32'(start_addr), 32'h0);
        chk("rst_addr", {mem_addr, mem_din}, 32'h0);
        reset = 1'b0;
        tick(2);

        fixed_pay = {8'h11, 8'h22, 8'h33};
        run_file(16'h4000, 16'h4002, -1, 1'b0, 0, IDX, 1'b0);
        fixed_pay = {8'h11, 8'h22, 8'h33};
        run_file(16'h4000, 16'h4002, -1, 1'b1, 0, IDX, 1'b0);
        run_file(16'h0010, 16'h000F, -1, 1'b0, 3, IDX, 1'b0);
        fixed_pay = {8'hAA};
        run_file(16'hFFFF, 16'hFFFF, -1, 1'b0, 2, IDX, 1'b0);
        run_file(16'h1234, 16'h1236, 6, 1'b0, 0, IDX, 1'b0);
        run_file(16'h2000, 16'h2004, -1, 1'b0, 2, IDX, 1'b0);
        reset_mid_data();
        run_file(16'h3000, 16'h3002, -1, 1'b0, 0, 5'd3, 1'b0);
        run_file(16'h0100, 16'h0101, -1, 1'b0, 1, IDX, 1'b1);
        run_file(16'h0100, 16'h0101, 0, 1'b0, 0, IDX, 1'b0);

        for (int k = 0; k < 40; k++) begin
            len = $urandom_range(1, 8);
            r = $urandom_range(0, 9);
            s = (r < 2) ? 16'(65536 - len) : 16'($urandom_range(0, 65536 - len));
            e = s + 16'(len - 1);
            if (r == 9 && s != 16'h0000) e = 16'($urandom_range(0, int'(s) - 1));
            nsend = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 4 + len + 1) : -1;
            run_file(s, e, nsend, $urandom_range(0, 3) == 0, $urandom_range(0, 2),
                     ($urandom_range(0, 7) == 0) ? 5'd1 : IDX, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
